// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : product_accumulator
// Brief   : Sums a programmed number of 32-bit unsigned products into an
//           ACC_W-bit accumulator with a valid/ready result handshake.
//           Define PRODUCT_ACC_SATURATE_EN to clamp on overflow (wraps otherwise).
// Revision: 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_valid,
    input  logic [31:0]      prod,
    output logic             prod_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_len;
    logic             r_overflow;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_inc;

    // One extra bit on the adder exposes the carry out of the accumulator MSB.
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, prod};
    assign w_carry   = w_sum[ACC_W];
    assign w_cnt_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef PRODUCT_ACC_SATURATE_EN
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_count    <= '0;
            r_len      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_len      <= len;
                        r_state    <= (len == '0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (prod_valid) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_cnt_inc;
                        if (w_carry) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_cnt_inc == r_len) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The accumulator itself is the result, so it holds after the handshake.
    assign result     = r_acc;
    assign overflow   = r_overflow;
    assign prod_ready = (r_state == S_ACC);
    assign res_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_product_accumulator
// Brief   : Randomized and directed self-checking bench for product_accumulator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int ACC_W = 33;
    localparam int CNT_W = 8;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b1;
    logic             start      = 1'b0;
    logic [CNT_W-1:0] len        = '0;
    logic             prod_valid = 1'b0;
    logic [31:0]      prod       = '0;
    logic             res_ready  = 1'b0;
    logic             prod_ready;
    logic             res_valid;
    logic [ACC_W-1:0] result;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] terms [16];

    product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_ready(prod_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact arithmetic on a wide integer, then wrap or clamp.
    function automatic void model(input int n, output logic [63:0] r, output logic o);
        longint unsigned top = 64'd1 << ACC_W;
        longint unsigned a   = 0;
        longint unsigned s;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = a + longint'(terms[i]);
            if (s >= top) begin
                o = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
                a = top - 1;
`else
                a = s - top;
`endif
            end else begin
                a = s;
            end
        end
        r = a;
    endfunction

    task automatic run_job(input int n, input int max_gap, input int bp, input bit poke_start);
        logic [63:0] er;
        logic        eo;
        int          gaps;
        model(n, er, eo);
        check("idle_busy", busy, 0);
        start = 1'b1;
        len   = n[CNT_W-1:0];
        tick();
        start = 1'b0;
        len   = CNT_W'($urandom);
        if (n == 0) begin
            check("len0_prod_ready", prod_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
            repeat (gaps) begin
                prod_valid = 1'b0;
                prod       = $urandom;
                tick();
                check("gap_prod_ready", prod_ready, 1);
                check("gap_res_valid", res_valid, 0);
            end
            prod_valid = 1'b1;
            prod       = terms[i];
            if (poke_start && i == 0) begin
                start = 1'b1;
                len   = CNT_W'(9);
            end
            tick();
            prod_valid = 1'b0;
            start      = 1'b0;
            if (i < n - 1) begin
                check("res_valid_early", res_valid, 0);
            end
        end
        check("done_res_valid", res_valid, 1);
        check("done_result", result, er);
        check("done_overflow", overflow, eo);
        check("done_prod_ready", prod_ready, 0);
        check("done_busy", busy, 1);
        repeat (bp) begin
            res_ready = 1'b0;
            tick();
            check("hold_res_valid", res_valid, 1);
            check("hold_result", result, er);
        end
        // A start coinciding with the handshake must not launch a job.
        res_ready = 1'b1;
        start     = 1'b1;
        len       = CNT_W'(1);
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check("after_hs_busy", busy, 0);
        check("after_hs_res_valid", res_valid, 0);
        check("after_hs_result", result, er);
        tick();
        check("idle_stays", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_prod_ready"}, prod_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        #2 rst_n = 1'b1;

        // Three back-to-back terms; first start right after reset release.
        terms[0] = 32'd6; terms[1] = 32'd15; terms[2] = 32'd99;
        run_job(3, 0, 0, 1'b0);
        check("sum3_value", result, 120);

        // Largest 16x16 product plus one, with gaps and backpressure.
        terms[0] = 32'd4294836225; terms[1] = 32'd1;
        run_job(2, 3, 5, 1'b0);
        check("bp_value", result, 64'd4294836226);

        run_job(0, 0, 2, 1'b0);
        check("len0_value", result, 0);

        terms[0] = 32'hFFFF_FFFF; terms[1] = 32'hFFFF_FFFF; terms[2] = 32'hFFFF_FFFF;
        run_job(3, 1, 1, 1'b0);
        check("ovf_flag", overflow, 1);
`ifdef PRODUCT_ACC_SATURATE_EN
        check("ovf_value", result, 64'h1_FFFF_FFFF);
`else
        check("ovf_value", result, 64'h0_FFFF_FFFD);
`endif

        // Start pulsed with len=9 while accumulating must be ignored.
        for (int i = 0; i < 3; i++) terms[i] = $urandom_range(0, 1000);
        run_job(3, 2, 0, 1'b1);

        // Reset pulsed between edges in the middle of a job.
        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod       = 32'd1000 + 32'(i);
            tick();
        end
        prod_valid = 1'b0;
        check("midjob_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_midjob");
        #2 rst_n = 1'b1;
        terms[0] = 32'd7;
        run_job(1, 0, 0, 1'b0);
        check("post_reset_value", result, 7);

        for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                terms[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            run_job(n, (j % 2) * 2, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator and result width in bits, legal range 33..64.
REQ-002 SHALL have parameter CNT_W, default 8: term-count width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: begin a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port len, input, CNT_W: number of products to sum; captured when start is accepted.
REQ-007 SHALL have port prod_valid, input, 1: prod carries a valid 32-bit unsigned product from the 16x16 multiplier.
REQ-008 SHALL have port prod, input, 32: unsigned product term.
REQ-009 SHALL have port prod_ready, output, 1: block accepts a term this cycle.
REQ-010 SHALL have port res_valid, output, 1: result is valid.
REQ-011 SHALL have port res_ready, input, 1: downstream consumes result.
REQ-012 SHALL have port result, output, ACC_W: accumulated sum.
REQ-013 SHALL have port overflow, output, 1: sticky flag, sum exceeded 2^ACC_W-1 during the current job.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 IDLE, start=1, len!=0 SHALL: clear acc, count and overflow; capture len; go to ACC next cycle.
REQ-017 IDLE, start=1, len=0 SHALL: clear acc and overflow; go directly to DONE with result 0.
REQ-018 prod_ready SHALL be 1 only in ACC; it is combinational from state.
REQ-019 A term SHALL transfer on a rising edge where prod_valid=1 and prod_ready=1: acc <= acc + zero-extended prod, count <= count+1.
REQ-020 prod_valid=0 in ACC SHALL leave acc and count unchanged; no timeout.
REQ-021 When the transfer makes count equal to the captured len, the FSM SHALL go to DONE on the same edge; at most one term is accepted per cycle.
REQ-022 In DONE, res_valid SHALL be 1 and result SHALL equal acc, stable until the handshake completes.
REQ-023 res_valid and res_ready both high at an edge SHALL return the FSM to IDLE; result then holds its last value.
REQ-024 start SHALL be ignored in ACC and DONE; a start asserted in the same cycle as the DONE->IDLE handshake is ignored.
REQ-025 Latency from the last accepted term to res_valid=1 SHALL be exactly 1 cycle.
REQ-026 A carry out of bit ACC_W-1 on any addition SHALL set overflow, which stays set until the next accepted start or reset.
REQ-027 overflow SHALL be valid whenever res_valid=1.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, acc=0, count=0, captured len=0, overflow=0, result=0, res_valid=0, prod_ready=0, busy=0.
REQ-029 Reset asserted mid-job (ACC or DONE) SHALL discard the job; after release the block waits in IDLE for start.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro PRODUCT_ACC_SATURATE_EN defined: on carry-out, acc SHALL clamp to 2^ACC_W-1 and hold there for the rest of the job; overflow is set.
REQ-032 Macro PRODUCT_ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; overflow is still set.

Verification
REQ-033 Sum of three terms: start, len=3, terms 6, 15, 99 each with prod_valid=1 back-to-back -> res_valid one cycle after the third term, result=120, overflow=0.
REQ-034 Backpressure and gaps: len=2, terms 4294836225 (65535*65535) and 1 with idle cycles between them, res_ready held 0 for 5 cycles -> result=4294836226, held stable until res_ready=1, then IDLE.
REQ-035 len=0: start with len=0 -> DONE next cycle, result=0, prod_ready never asserted.
REQ-036 Overflow, ACC_W=33: len=3, terms 0xFFFFFFFF x3 -> overflow=1; result=0x0FFFFFFFD when wrapping, 0x1FFFFFFFF with PRODUCT_ACC_SATURATE_EN.
REQ-037 Reset mid-job: len=4, two terms accepted, then rst_n pulsed low between edges -> all outputs 0 immediately; next job with len=1 and term 7 -> result=7.
REQ-038 Ignored start: start pulsed during ACC with len=9 -> captured len and count unaffected; job completes with the original len.
